assertion_timer_bank: RTL and testbench

ASSERTION_TIMER_BANK -- requirements
Module: assertion_timer_bank

---
 rtl/assertion_timer_bank_pkg.sv | 15 +
 rtl/assertion_timer_channel.sv | 96 +++++++++
 rtl/assertion_timer_bank.sv | 39 +++
 tb/tb_assertion_timer_bank.sv | 131 +++++++++++++
 4 files changed

// File: rtl/assertion_timer_bank_pkg.sv
// rtl/assertion_timer_bank_pkg.sv - shared mode and state types for the assertion timer bank
package assertion_timer_bank_pkg;

    typedef enum logic {
        ASRT_MODE_ECHO = 1'b0,
        ASRT_MODE_TRIP = 1'b1
    } asrt_mode_e;

    typedef enum logic [1:0] {
        ASRT_IDLE = 2'd0,
        ASRT_ECHO = 2'd1,
        ASRT_TRIP = 2'd2
    } asrt_state_e;

endpackage

// File: rtl/assertion_timer_channel.sv
// rtl/assertion_timer_channel.sv - one echo/trip timer channel (optional ASSERTION_TIMER_OVERRUN_EN)
module assertion_timer_channel
    import assertion_timer_bank_pkg::*;
#(
    parameter int CNT_W     = 4,
    parameter int IMMEDIATE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger,
    input  logic             mode,
    input  logic [CNT_W-1:0] latency,
    input  logic             flush,
    input  logic             ovr_clr,
    output logic             assertion,
    output logic             busy,
    output logic             overrun
);

    asrt_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_cyc;
    logic             lat_zero;
    logic             timed;
    logic             imm;

    // Treating 0 like 1 keeps the counter from ever wrapping below zero.
    assign last_cyc = (cnt_q <= CNT_W'(1));
    assign lat_zero = (latency == '0);
    assign timed    = (state_q == ASRT_ECHO) || ((state_q == ASRT_TRIP) && last_cyc);
    assign imm      = trigger && (((mode == ASRT_MODE_ECHO) && (IMMEDIATE != 0)) ||
                                  ((mode == ASRT_MODE_TRIP) && lat_zero));
    assign busy     = (state_q != ASRT_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ASRT_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        assertion = 1'b0;
        if (flush) begin
            state_d = ASRT_IDLE;
            cnt_d   = '0;
        end else begin
            assertion = !rst && (timed || imm);
            if (trigger) begin
                if (lat_zero) begin
                    state_d = ASRT_IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = (mode == ASRT_MODE_TRIP) ? ASRT_TRIP : ASRT_ECHO;
                    cnt_d   = latency;
                end
            end else if (state_q != ASRT_IDLE) begin
                if (last_cyc) begin
                    state_d = ASRT_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        end
    end

`ifdef ASSERTION_TIMER_OVERRUN_EN
    logic ovr_evt;
    logic ovr_q;

    // A retrigger on the final trip cycle still emits its pulse, so it is not a loss.
    assign ovr_evt = trigger && !flush && (state_q == ASRT_TRIP) && !last_cyc;
    assign overrun = ovr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_q <= 1'b0;
        end else if (ovr_evt) begin
            ovr_q <= 1'b1;
        end else if (ovr_clr) begin
            ovr_q <= 1'b0;
        end
    end
`else
    logic unused_ovr_clr;
    assign unused_ovr_clr = ovr_clr;
    assign overrun        = 1'b0;
`endif

endmodule

// File: rtl/assertion_timer_bank.sv
// rtl/assertion_timer_bank.sv - bank of independent assertion timers (optional ASSERTION_TIMER_OVERRUN_EN)
module assertion_timer_bank
    import assertion_timer_bank_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int CNT_W     = 4,
    parameter int IMMEDIATE = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       trigger,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS*CNT_W-1:0] latency,
    input  logic [CHANNELS-1:0]       flush,
    input  logic [CHANNELS-1:0]       ovr_clr,
    output logic [CHANNELS-1:0]       assertion,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS-1:0]       overrun
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assertion_timer_channel #(
            .CNT_W     (CNT_W),
            .IMMEDIATE (IMMEDIATE)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .trigger   (trigger[i]),
            .mode      (mode[i]),
            .latency   (latency[i*CNT_W +: CNT_W]),
            .flush     (flush[i]),
            .ovr_clr   (ovr_clr[i]),
            .assertion (assertion[i]),
            .busy      (busy[i]),
            .overrun   (overrun[i])
        );
    end

endmodule

// File: tb/tb_assertion_timer_bank.sv
// tb/tb_assertion_timer_bank.sv - directed self-checking bench for assertion_timer_bank
module tb_assertion_timer_bank;

    localparam int CHANNELS = 4;
    localparam int CNT_W    = 4;
`ifdef ASSERTION_TIMER_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [CHANNELS-1:0]       trigger = '0;
    logic [CHANNELS-1:0]       mode = '0;
    logic [CHANNELS*CNT_W-1:0] latency = '0;
    logic [CHANNELS-1:0]       flush = '0;
    logic [CHANNELS-1:0]       ovr_clr = '0;
    logic [CHANNELS-1:0]       assertion;
    logic [CHANNELS-1:0]       busy;
    logic [CHANNELS-1:0]       overrun;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    assertion_timer_bank #(
        .CHANNELS  (CHANNELS),
        .CNT_W     (CNT_W),
        .IMMEDIATE (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .trigger   (trigger),
        .mode      (mode),
        .latency   (latency),
        .flush     (flush),
        .ovr_clr   (ovr_clr),
        .assertion (assertion),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic arm(input int ch, input logic m, input int l);
        logic [31:0] lv;
        lv = l;
        trigger[ch] = 1'b1;
        mode[ch]    = m;
        latency[ch*CNT_W +: CNT_W] = lv[CNT_W-1:0];
    endtask

    initial begin
        for (int c = 0; c < 86; c++) begin
            @(posedge clk);
            #1;
            cyc     = c;
            rst     = (c < 3) || (c == 73) || (c == 74);
            trigger = '0;
            mode    = '0;
            latency = '0;
            flush   = '0;
            ovr_clr = '0;
            case (c)
                1:  arm(0, 1'b1, 0);
                5:  arm(0, 1'b0, 0);
                10: arm(0, 1'b0, 3);
                20: arm(1, 1'b1, 5);
                30: arm(1, 1'b1, 0);
                40: arm(2, 1'b1, 6);
                42: arm(2, 1'b1, 2);
                50: ovr_clr[2] = 1'b1;
                53: arm(2, 1'b1, 2);
                55: arm(2, 1'b1, 1);
                60: arm(3, 1'b0, 4);
                61: arm(0, 1'b0, 3);
                62: begin arm(3, 1'b1, 0); flush[3] = 1'b1; end
                70: arm(1, 1'b1, 8);
                73: arm(0, 1'b1, 0);
                75: arm(1, 1'b1, 1);
                default: ;
            endcase

            @(negedge clk);
            if (c == 1) begin
                check("rst_asrt", int'(assertion), 0);
                check("rst_busy", int'(busy), 0);
                check("rst_ovr", int'(overrun), 0);
            end
            if (c >= 4 && c <= 15) begin
                check("ch0_echo_asrt", int'(assertion[0]), int'(c == 5 || (c >= 10 && c <= 13)));
                check("ch0_echo_busy", int'(busy[0]), int'(c >= 11 && c <= 13));
            end
            if (c >= 19 && c <= 31) begin
                check("ch1_trip_asrt", int'(assertion[1]), int'(c == 25 || c == 30));
                check("ch1_trip_busy", int'(busy[1]), int'(c >= 21 && c <= 25));
            end
            if (c >= 39 && c <= 58) begin
                check("ch2_retrig_asrt", int'(assertion[2]), int'(c == 44 || c == 55 || c == 56));
                check("ch2_ovr", int'(overrun[2]), int'(OVR_EN && c >= 43 && c <= 50));
            end
            if (c >= 59 && c <= 66) begin
                check("ch3_flush_asrt", int'(assertion[3]), int'(c == 60 || c == 61));
                check("ch3_flush_busy", int'(busy[3]), int'(c == 61 || c == 62));
                check("ch0_indep_asrt", int'(assertion[0]), int'(c >= 61 && c <= 64));
            end
            if (c >= 69 && c <= 80) begin
                check("ch1_rst_asrt", int'(assertion[1]), int'(c == 76));
                check("ch1_rst_busy", int'(busy[1]), int'(c == 71 || c == 72 || c == 76));
                check("ch0_rst_asrt", int'(assertion[0]), 0);
            end
            if (c == 73 || c == 74) begin
                check("midrst_asrt", int'(assertion), 0);
                check("midrst_busy", int'(busy), 0);
                check("midrst_ovr", int'(overrun), 0);
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
